// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the oversampling UART receiver: parity modes, FSM states,
// oversampling ratio and the small helpers used by the sampler.
`timescale 1ns/1ps
package uart_pkg;

  localparam int PAR_NONE      = 0;
  localparam int PAR_ODD       = 1;
  localparam int PAR_EVEN      = 2;
  localparam int OVERSAMPLE    = 16;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Zero-extended data does not disturb the XOR, so one width serves every DATA_BITS.
  function automatic logic par_err(input logic [MAX_DATA_BITS-1:0] data, input logic par_bit,
                                   input int mode);
    logic err;
    case (mode)
      PAR_ODD:  err = ~(^data ^ par_bit);
      PAR_EVEN: err = ^data ^ par_bit;
      default:  err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered head entry, registered count/valid and a
// one-cycle overrun pulse when a write is dropped because the FIFO is full.
`timescale 1ns/1ps
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d, ovr_q, ovr_d;
  logic             do_pop_s, do_push_s;

  // Pointer, occupancy and head-entry next-state logic.
  always_comb begin
    do_pop_s  = rd_en & (count_q != {CNT_W{1'b0}});
    do_push_s = wr_en & ((count_q != CNT_W'(DEPTH)) | do_pop_s);
    wr_ptr_d  = do_push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovr_d   = wr_en & ~do_push_s;
    valid_d = (count_d != {CNT_W{1'b0}});
    // The incoming word becomes the head when it lands where the read pointer will point.
    if (do_push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wr_data;
    end else if (count_d != {CNT_W{1'b0}}) begin
      head_d = mem_q[rd_ptr_d];
    end else begin
      head_d = head_q;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      head_q   <= {WIDTH{1'b0}};
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rd_data = head_q;
  assign valid   = valid_q;
  assign count   = count_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampling UART receiver with majority voting feeding a valid/ready FIFO.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
`timescale 1ns/1ps
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          sys_rst_n,
  input  logic                          uart_rxd,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_frame_err,
  output logic                          m_parity_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          overrun,
`ifdef UART_RX_BREAK_DET_EN
  output logic                          break_det,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int DIV_W = $clog2(DIV);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int ENT_W = DATA_BITS + 2;

  if (DIV < 2 || STOP_BITS < 1 || STOP_BITS > 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_rx_fifo: unsupported parameter set");
  end

  rx_state_e            state_q, state_d;
  logic                 rx_meta_q, rxs_q, rxs_prev_q;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [3:0]           samp_q, samp_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 s7_q, s7_d, s8_q, s8_d, par_q, par_d;
  logic                 tick_s, vote_s, at_vote_s, at_end_s, start_edge_s;
  logic                 fifo_push, push_perr, push_ferr;
  logic [ENT_W-1:0]     head_s;
`ifdef UART_RX_BREAK_DET_EN
  logic                 brk_q, brk_d, wait_q, wait_d;
`endif

  assign tick_s    = (state_q != ST_IDLE) && (div_cnt_q == DIV_W'(DIV - 1));
  assign vote_s    = majority3(s7_q, s8_q, rxs_q);
  assign at_vote_s = tick_s && (samp_q == 4'd9);
  assign at_end_s  = tick_s && (samp_q == 4'd15);
`ifdef UART_RX_BREAK_DET_EN
  assign start_edge_s = rxs_prev_q & ~rxs_q & ~wait_q;
`else
  assign start_edge_s = rxs_prev_q & ~rxs_q;
`endif

  // Bit timing, sampling and receive state machine.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    fifo_push = 1'b0;
    push_perr = 1'b0;
    push_ferr = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk_d     = 1'b0;
    wait_d    = wait_q;
`endif
    if (state_q == ST_IDLE) begin
      div_cnt_d = {DIV_W{1'b0}};
      samp_d    = 4'd0;
    end else if (tick_s) begin
      div_cnt_d = {DIV_W{1'b0}};
      samp_d    = samp_q + 4'd1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      samp_d    = samp_q;
    end
    s7_d = (tick_s && samp_q == 4'd7) ? rxs_q : s7_q;
    s8_d = (tick_s && samp_q == 4'd8) ? rxs_q : s8_q;

    case (state_q)
      ST_IDLE: begin
`ifdef UART_RX_BREAK_DET_EN
        wait_d = wait_q & ~rxs_q;
`endif
        state_d = start_edge_s ? ST_START : ST_IDLE;
      end
      ST_START: begin
        if (at_vote_s && vote_s) begin
          state_d = ST_IDLE;
        end else if (at_end_s) begin
          state_d   = ST_DATA;
          bit_idx_d = {BIT_W{1'b0}};
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        shift_d = at_vote_s ? {vote_s, shift_q[DATA_BITS-1:1]} : shift_q;
        if (at_end_s && (bit_idx_q == BIT_W'(DATA_BITS - 1))) begin
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end else if (at_end_s) begin
          bit_idx_d = bit_idx_q + BIT_W'(1);
        end else begin
          bit_idx_d = bit_idx_q;
        end
      end
      ST_PARITY: begin
        par_d   = at_vote_s ? vote_s : par_q;
        state_d = at_end_s ? ST_STOP : ST_PARITY;
      end
      ST_STOP: begin
        // Return to IDLE at the stop vote so a following start edge is never missed.
        if (at_vote_s) begin
          push_ferr = ~vote_s;
          push_perr = par_err(MAX_DATA_BITS'(shift_q), par_q, PARITY);
          state_d   = ST_IDLE;
`ifdef UART_RX_BREAK_DET_EN
          if (!vote_s && (shift_q == {DATA_BITS{1'b0}}) && ((PARITY == PAR_NONE) || !par_q)) begin
            brk_d  = 1'b1;
            wait_d = 1'b1;
          end else begin
            fifo_push = 1'b1;
          end
`else
          fifo_push = 1'b1;
`endif
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Synchroniser and receiver state registers.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      div_cnt_q  <= {DIV_W{1'b0}};
      samp_q     <= 4'd0;
      bit_idx_q  <= {BIT_W{1'b0}};
      shift_q    <= {DATA_BITS{1'b0}};
      s7_q       <= 1'b1;
      s8_q       <= 1'b1;
      par_q      <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rxd;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      samp_q     <= samp_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      s7_q       <= s7_d;
      s8_q       <= s8_d;
      par_q      <= par_d;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // Break pulse and the re-arm guard that waits for the line to return high.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      brk_q  <= 1'b0;
      wait_q <= 1'b0;
    end else begin
      brk_q  <= brk_d;
      wait_q <= wait_d;
    end
  end

  assign break_det = brk_q;
`endif

  uart_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (sys_rst_n),
    .wr_en   (fifo_push),
    .wr_data ({push_perr, push_ferr, shift_q}),
    .rd_en   (m_ready),
    .rd_data (head_s),
    .valid   (m_valid),
    .count   (fifo_count),
    .overrun (overrun)
  );

  assign m_data       = head_s[DATA_BITS-1:0];
  assign m_frame_err  = head_s[DATA_BITS];
  assign m_parity_err = head_s[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: an 8N1 receiver (432 clk/bit) and a 7E1 receiver (64 clk/bit).
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int BCLK_A = 432;
  localparam int BCLK_B = 64;

  typedef struct packed {
    logic       pe;
    logic       fe;
    logic [8:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       sys_rst_n, rxd_a, rxd_b, rdy_a, rdy_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       fe_a, pe_a, val_a, ovr_a, fe_b, pe_b, val_b, ovr_b;
  logic [2:0] cnt_a, cnt_b;
  int         errors = 0;
  int         checks = 0;
  int         ovr_cnt_b = 0;
  exp_t       q_a[$];
  exp_t       q_b[$];
`ifdef UART_RX_BREAK_DET_EN
  logic       brk_a, brk_b;
  int         brk_cnt_a = 0;
`endif

  always #10 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(50_000_000), .BAUD(115200), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd_a), .m_data(data_a),
    .m_frame_err(fe_a), .m_parity_err(pe_a), .m_valid(val_a), .m_ready(rdy_a),
    .overrun(ovr_a),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk_a),
`endif
    .fifo_count(cnt_a));

  uart_rx_fifo #(.CLK_FREQ(50_000_000), .BAUD(781250), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd_b), .m_data(data_b),
    .m_frame_err(fe_b), .m_parity_err(pe_b), .m_valid(val_b), .m_ready(rdy_b),
    .overrun(ovr_b),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk_b),
`endif
    .fifo_count(cnt_b));

  always @(posedge clk) begin
    if (ovr_b) ovr_cnt_b <= ovr_cnt_b + 1;
`ifdef UART_RX_BREAK_DET_EN
    if (brk_a) brk_cnt_a <= brk_cnt_a + 1;
`endif
  end

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_line(input bit to_b, input logic val, input int n);
    if (to_b) rxd_b = val; else rxd_a = val;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit to_b, input logic [8:0] data, input int nbits,
                            input int par_mode, input bit flip_par, input bit stop_low);
    int   bclk;
    logic pbit;
    bclk = to_b ? BCLK_B : BCLK_A;
    pbit = 1'b0;
    drive_line(to_b, 1'b0, bclk);
    for (int i = 0; i < nbits; i++) begin
      drive_line(to_b, data[i], bclk);
      pbit = pbit ^ data[i];
    end
    if (par_mode != 0) begin
      if (par_mode == 1) pbit = ~pbit;
      drive_line(to_b, pbit ^ flip_par, bclk);
    end
    drive_line(to_b, ~stop_low, bclk);
    if (stop_low) drive_line(to_b, 1'b1, bclk);
  endtask

  // Pops the head entry (observation only); got=0 if m_valid never rose.
  task automatic pop_entry(input bit from_b, output exp_t obs, output bit got);
    got = 1'b0;
    obs = '0;
    for (int i = 0; i < 20; i++) begin
      if (from_b ? val_b : val_a) begin
        obs  = from_b ? {pe_b, fe_b, 2'b00, data_b} : {pe_a, fe_a, 1'b0, data_a};
        got  = 1'b1;
        if (from_b) rdy_b = 1'b1; else rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({val_a, cnt_a, data_a, fe_a, pe_a, ovr_a} !== 15'd0) begin
      errors++;
      $display("FAIL reset_a: got v=%b c=%0d d=%h fe=%b pe=%b o=%b, want all 0",
               val_a, cnt_a, data_a, fe_a, pe_a, ovr_a);
    end
    checks++;
    if ({val_b, cnt_b, data_b, fe_b, pe_b, ovr_b} !== 14'd0) begin
      errors++;
      $display("FAIL reset_b: got v=%b c=%0d d=%h fe=%b pe=%b o=%b, want all 0",
               val_b, cnt_b, data_b, fe_b, pe_b, ovr_b);
    end
  endtask

  task automatic test_basic();
    exp_t e, o;
    bit   got;
    q_a.push_back('{pe: 1'b0, fe: 1'b0, d: 9'h0A5});
    send_frame(1'b0, 9'h0A5, 8, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if ({val_a, cnt_a} !== {1'b1, 3'd1}) begin
      errors++;
      $display("FAIL basic_count: got valid=%b count=%0d, want valid=1 count=1", val_a, cnt_a);
    end
    pop_entry(1'b0, o, got);
    e = q_a.pop_front();
    checks++;
    if (!got || o !== e) begin
      errors++;
      $display("FAIL basic_entry: got %b/%h, want %h", got, o, e);
    end
    checks++;
    if ({val_a, cnt_a} !== 4'd0) begin
      errors++;
      $display("FAIL basic_drain: got valid=%b count=%0d, want 0/0", val_a, cnt_a);
    end
  endtask

  task automatic test_false_start();
    exp_t e, o;
    bit   got;
    drive_line(1'b0, 1'b0, 100);
    drive_line(1'b0, 1'b1, 800);
    checks++;
    if ({val_a, cnt_a} !== 4'd0) begin
      errors++;
      $display("FAIL false_start: got valid=%b count=%0d, want 0/0", val_a, cnt_a);
    end
    q_a.push_back('{pe: 1'b0, fe: 1'b0, d: 9'h096});
    send_frame(1'b0, 9'h096, 8, 0, 1'b0, 1'b0);
    pop_entry(1'b0, o, got);
    e = q_a.pop_front();
    checks++;
    if (!got || o !== e) begin
      errors++;
      $display("FAIL false_start_resync: got %b/%h, want %h", got, o, e);
    end
  endtask

  task automatic test_parity();
    exp_t e, o;
    bit   got;
    q_b.push_back('{pe: 1'b0, fe: 1'b0, d: 9'h041});
    send_frame(1'b1, 9'h041, 7, 2, 1'b0, 1'b0);
    q_b.push_back('{pe: 1'b1, fe: 1'b0, d: 9'h041});
    send_frame(1'b1, 9'h041, 7, 2, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      pop_entry(1'b1, o, got);
      e = q_b.pop_front();
      checks++;
      if (!got || o !== e) begin
        errors++;
        $display("FAIL parity_entry%0d: got %b/%h, want %h", i, got, o, e);
      end
    end
  endtask

  task automatic test_frame_err();
    exp_t e, o;
    bit   got;
    q_a.push_back('{pe: 1'b0, fe: 1'b1, d: 9'h03C});
    send_frame(1'b0, 9'h03C, 8, 0, 1'b0, 1'b1);
    pop_entry(1'b0, o, got);
    e = q_a.pop_front();
    checks++;
    if (!got || o !== e) begin
      errors++;
      $display("FAIL frame_err_entry: got %b/%h, want %h", got, o, e);
    end
`ifdef UART_RX_BREAK_DET_EN
    begin
      int b0;
      b0 = brk_cnt_a;
      send_frame(1'b0, 9'h000, 8, 0, 1'b0, 1'b1);
      checks++;
      if (brk_cnt_a - b0 !== 1 || cnt_a !== 3'd0) begin
        errors++;
        $display("FAIL break_det: got pulses=%0d count=%0d, want 1 and 0", brk_cnt_a - b0, cnt_a);
      end
    end
`else
    q_a.push_back('{pe: 1'b0, fe: 1'b1, d: 9'h000});
    send_frame(1'b0, 9'h000, 8, 0, 1'b0, 1'b1);
    pop_entry(1'b0, o, got);
    e = q_a.pop_front();
    checks++;
    if (!got || o !== e) begin
      errors++;
      $display("FAIL break_entry: got %b/%h, want %h", got, o, e);
    end
`endif
    q_a.push_back('{pe: 1'b0, fe: 1'b0, d: 9'h081});
    send_frame(1'b0, 9'h081, 8, 0, 1'b0, 1'b0);
    pop_entry(1'b0, o, got);
    e = q_a.pop_front();
    checks++;
    if (!got || o !== e) begin
      errors++;
      $display("FAIL after_break_entry: got %b/%h, want %h", got, o, e);
    end
  endtask

  task automatic test_overrun();
    exp_t e, o;
    bit   got, seen;
    int   ov0;
    ov0 = ovr_cnt_b;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) q_b.push_back('{pe: 1'b0, fe: 1'b0, d: 9'(v)});
      send_frame(1'b1, 9'(v), 7, 2, 1'b0, 1'b0);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (cnt_b !== 3'd4 || ovr_cnt_b - ov0 !== 1) begin
      errors++;
      $display("FAIL overrun_full: got count=%0d pulses=%0d, want 4 and 1", cnt_b, ovr_cnt_b - ov0);
    end
    for (int i = 0; i < 4; i++) begin
      pop_entry(1'b1, o, got);
      e = q_b.pop_front();
      checks++;
      if (!got || o !== e) begin
        errors++;
        $display("FAIL overrun_drain%0d: got %b/%h, want %h", i, got, o, e);
      end
    end
    // Second pass: a pop lands on the same cycle as the fifth push.
    ov0 = ovr_cnt_b;
    for (int v = 1; v <= 5; v++) q_b.push_back('{pe: 1'b0, fe: 1'b0, d: 9'(v)});
    for (int v = 1; v <= 4; v++) send_frame(1'b1, 9'(v), 7, 2, 1'b0, 1'b0);
    seen = 1'b0;
    o = '0;
    fork
      send_frame(1'b1, 9'h005, 7, 2, 1'b0, 1'b0);
      begin
        for (int i = 0; i < 2000; i++) begin
          if (dut_b.fifo_push) begin
            seen = 1'b1;
            o = {pe_b, fe_b, 2'b00, data_b};
            rdy_b = 1'b1;
            @(negedge clk);
            rdy_b = 1'b0;
            break;
          end
          @(negedge clk);
        end
      end
    join
    e = q_b.pop_front();
    checks++;
    if (!seen || o !== e) begin
      errors++;
      $display("FAIL coincident_pop: got seen=%b head=%h, want seen=1 head=%h", seen, o, e);
    end
    checks++;
    if (cnt_b !== 3'd4 || ovr_cnt_b != ov0) begin
      errors++;
      $display("FAIL coincident_count: got count=%0d pulses=%0d, want 4 and 0", cnt_b, ovr_cnt_b - ov0);
    end
    for (int i = 0; i < 4; i++) begin
      pop_entry(1'b1, o, got);
      e = q_b.pop_front();
      checks++;
      if (!got || o !== e) begin
        errors++;
        $display("FAIL coincident_drain%0d: got %b/%h, want %h", i, got, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    bit   got;
    logic [7:0] ch;
    send_frame(1'b0, 9'h011, 8, 0, 1'b0, 1'b0);
    ch = 8'h5A;
    drive_line(1'b0, 1'b0, BCLK_A);
    for (int i = 0; i < 3; i++) drive_line(1'b0, ch[i], BCLK_A);
    drive_line(1'b0, ch[3], 200);
    sys_rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({val_a, cnt_a, data_a, fe_a, pe_a, ovr_a} !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b c=%0d d=%h fe=%b pe=%b o=%b, want all 0",
               val_a, cnt_a, data_a, fe_a, pe_a, ovr_a);
    end
    rxd_a = 1'b1;
    repeat (3) @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (500) @(negedge clk);
    checks++;
    if ({val_a, cnt_a} !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_empty: got valid=%b count=%0d, want 0/0", val_a, cnt_a);
    end
    q_a.delete();
    q_a.push_back('{pe: 1'b0, fe: 1'b0, d: 9'h05A});
    send_frame(1'b0, 9'h05A, 8, 0, 1'b0, 1'b0);
    pop_entry(1'b0, o, got);
    e = q_a.pop_front();
    checks++;
    if (!got || o !== e) begin
      errors++;
      $display("FAIL reset_mid_rx: got %b/%h, want %h", got, o, e);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    sys_rst_n = 1'b1;
    repeat (20) @(negedge clk);
    test_reset();
    test_basic();
    test_false_start();
    test_parity();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
